// File: rtl/ac_walker.sv
// ac_walker: walks an n_rows x n_cols tile and sequences the AC register commands.
// Column-major walking is compiled in only when AC_WALK_COLMODE_EN is defined.
module ac_walker #(
    parameter int CNT_W  = 8,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              col_mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] k,
    input  logic [CNT_W-1:0]  n_rows,
    input  logic [CNT_W-1:0]  n_cols,
    output logic              ac_load,
    output logic [ADDR_W-1:0] ac_data,
    output logic              ac_inc,
    output logic              ac_inck,
    output logic              ac_reset,
    output logic              elem_valid,
    output logic [CNT_W-1:0]  elem_row,
    output logic [CNT_W-1:0]  elem_col,
    output logic [ADDR_W-1:0] elem_addr,
    output logic              elem_last,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PRIME = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ABORT = 3'd4;

    localparam logic [1:0] CMD_NONE = 2'd0;
    localparam logic [1:0] CMD_INC  = 2'd1;
    localparam logic [1:0] CMD_INCK = 2'd2;
    localparam logic [1:0] CMD_LOAD = 2'd3;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] k_q, k_d;
    logic [CNT_W-1:0]  rows_q, rows_d;
    logic [CNT_W-1:0]  cols_q, cols_d;
    logic [ADDR_W-1:0] lb_q, lb_d;
    logic [CNT_W-1:0]  row_q, row_d;
    logic [CNT_W-1:0]  col_q, col_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ac_load_q, ac_inc_q, ac_reset_q, reset_d;
    logic [ADDR_W-1:0] ac_data_q, data_d;
    logic [1:0]        cmd_d;
    logic              show;
    logic              colm;
    logic [CNT_W-1:0]  rows_m1, cols_m1;

`ifdef AC_WALK_COLMODE_EN
    logic colm_q, colm_d;
    logic ac_inck_q;
    assign colm    = colm_q;
    assign ac_inck = ac_inck_q;
`else
    logic unused_col_mode;
    assign unused_col_mode = col_mode;
    assign colm    = 1'b0;
    assign ac_inck = 1'b0;
`endif

    assign rows_m1 = rows_q - CNT_W'(1);
    assign cols_m1 = cols_q - CNT_W'(1);

    // AC holds the shown element's address in every elem_valid cycle; the command
    // registered alongside it moves AC to the next element at the following edge.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        k_d     = k_q;
        rows_d  = rows_q;
        cols_d  = cols_q;
        lb_d    = lb_q;
        row_d   = '0;
        col_d   = '0;
        addr_d  = '0;
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        reset_d = 1'b0;
        cmd_d   = CMD_NONE;
        data_d  = '0;
        show    = 1'b0;
`ifdef AC_WALK_COLMODE_EN
        colm_d  = colm_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    base_d = base_addr;
                    k_d    = k;
                    rows_d = n_rows;
                    cols_d = n_cols;
`ifdef AC_WALK_COLMODE_EN
                    colm_d = col_mode;
`endif
                    if (n_rows == '0 || n_cols == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_PRIME;
                        cmd_d   = CMD_LOAD;
                        data_d  = base_addr;
                        busy_d  = 1'b1;
                    end
                end
            end
            S_PRIME: begin
                if (abort) begin
                    state_d = S_ABORT;
                    reset_d = 1'b1;
                end else begin
                    state_d = S_RUN;
                    show    = 1'b1;
                    lb_d    = base_q;
                    addr_d  = base_q;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_ABORT;
                    reset_d = 1'b1;
                end else if (last_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    show = 1'b1;
                    if (colm && row_q != rows_m1) begin
                        row_d  = row_q + CNT_W'(1);
                        col_d  = col_q;
                        addr_d = addr_q + k_q;
                    end else if (colm) begin
                        col_d  = col_q + CNT_W'(1);
                        addr_d = base_q + ADDR_W'(col_q) + ADDR_W'(1);
                    end else if (col_q != cols_m1) begin
                        row_d  = row_q;
                        col_d  = col_q + CNT_W'(1);
                        addr_d = addr_q + ADDR_W'(1);
                    end else begin
                        row_d  = row_q + CNT_W'(1);
                        lb_d   = lb_q + k_q;
                        addr_d = lb_q + k_q;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ABORT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (show) begin
            busy_d  = 1'b1;
            valid_d = 1'b1;
            last_d  = (row_d == rows_m1) && (col_d == cols_m1);
            if (!last_d) begin
                if (colm && row_d != rows_m1) begin
                    cmd_d = CMD_INCK;
                end else if (colm) begin
                    cmd_d  = CMD_LOAD;
                    data_d = base_q + ADDR_W'(col_d) + ADDR_W'(1);
                end else if (col_d != cols_m1) begin
                    cmd_d = CMD_INC;
                end else begin
                    cmd_d  = CMD_LOAD;
                    data_d = lb_d + k_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            k_q        <= '0;
            rows_q     <= '0;
            cols_q     <= '0;
            lb_q       <= '0;
            row_q      <= '0;
            col_q      <= '0;
            addr_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ac_load_q  <= 1'b0;
            ac_data_q  <= '0;
            ac_inc_q   <= 1'b0;
            ac_reset_q <= 1'b0;
`ifdef AC_WALK_COLMODE_EN
            colm_q     <= 1'b0;
            ac_inck_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            k_q        <= k_d;
            rows_q     <= rows_d;
            cols_q     <= cols_d;
            lb_q       <= lb_d;
            row_q      <= row_d;
            col_q      <= col_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ac_load_q  <= (cmd_d == CMD_LOAD);
            ac_data_q  <= data_d;
            ac_inc_q   <= (cmd_d == CMD_INC);
            ac_reset_q <= reset_d;
`ifdef AC_WALK_COLMODE_EN
            colm_q     <= colm_d;
            ac_inck_q  <= (cmd_d == CMD_INCK);
`endif
        end
    end

    assign ac_load    = ac_load_q;
    assign ac_data    = ac_data_q;
    assign ac_inc     = ac_inc_q;
    assign ac_reset   = ac_reset_q;
    assign elem_valid = valid_q;
    assign elem_row   = row_q;
    assign elem_col   = col_q;
    assign elem_addr  = addr_q;
    assign elem_last  = last_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_ac_walker.sv
// Bench for ac_walker: reference tile model feeding an element scoreboard, plus
// a behavioural AC register driven by the walker's command outputs.
module tb_ac_walker;
    localparam int CNT_W  = 8;
    localparam int ADDR_W = 16;
    localparam int EW     = 2 * CNT_W + ADDR_W + 1;
`ifdef AC_WALK_COLMODE_EN
    localparam bit COLM_EN = 1'b1;
`else
    localparam bit COLM_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              start, abort, col_mode;
    logic [ADDR_W-1:0] base_addr, k;
    logic [CNT_W-1:0]  n_rows, n_cols;
    logic              ac_load, ac_inc, ac_inck, ac_reset;
    logic [ADDR_W-1:0] ac_data;
    logic              elem_valid, elem_last, busy, done;
    logic [CNT_W-1:0]  elem_row, elem_col;
    logic [ADDR_W-1:0] elem_addr;

    int checks = 0;
    int errors = 0;
    int cmd_cnt = 0;
    int inck_cnt = 0;
    logic [EW-1:0]     exp_q[$];
    logic [ADDR_W-1:0] ac_m = '0;

    // clock / reset
    always #5 clk = ~clk;

    ac_walker #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .col_mode(col_mode),
        .base_addr(base_addr), .k(k), .n_rows(n_rows), .n_cols(n_cols),
        .ac_load(ac_load), .ac_data(ac_data), .ac_inc(ac_inc), .ac_inck(ac_inck),
        .ac_reset(ac_reset), .elem_valid(elem_valid), .elem_row(elem_row),
        .elem_col(elem_col), .elem_addr(elem_addr), .elem_last(elem_last),
        .busy(busy), .done(done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // behavioural AC register
    always @(posedge clk) begin
        if (ac_reset)     ac_m <= '0;
        else if (ac_load) ac_m <= ac_data;
        else if (ac_inc)  ac_m <= ac_m + 16'd1;
        else if (ac_inck) ac_m <= ac_m + k;
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [EW-1:0] act;
        if (!reset) begin
            chk("cmd_onehot", 64'($countones({ac_load, ac_inc, ac_inck, ac_reset}) <= 1), 1);
            if (!ac_load) chk("ac_data_idle", ac_data, 0);
            if (ac_load || ac_inc || ac_inck) cmd_cnt++;
            if (ac_inck) inck_cnt++;
            if (elem_valid) begin
                chk("elem_vs_ac", elem_addr, ac_m);
                act = {elem_row, elem_col, elem_addr, elem_last};
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL elem_unexpected actual=%0h required=none", act);
                end else begin
                    chk("elem", act, exp_q.pop_front());
                end
            end
        end
    end

    // reference model: element e of the walk sits at base + row*k + col
    task automatic push_exp(input logic [15:0] b, input logic [15:0] kk, input logic [7:0] r,
                            input logic [7:0] c, input bit use_col, input int count);
        int n, rr, cc;
        logic [15:0] a;
        n = int'(r) * int'(c);
        for (int e = 0; e < count; e++) begin
            if (use_col) begin cc = e / int'(r); rr = e % int'(r); end
            else begin rr = e / int'(c); cc = e % int'(c); end
            a = b + 16'(rr * int'(kk)) + 16'(cc);
            exp_q.push_back({8'(rr), 8'(cc), a, (e == n - 1)});
        end
    endtask

    // driver: called at a negedge; start is presented in that cycle
    task automatic run_walk(input logic [15:0] b, input logic [15:0] kk, input logic [7:0] r,
                            input logic [7:0] c, input logic cm, input int abort_at,
                            input int spur_at);
        int n, n_exp, cyc, done_cyc, exp_inck;
        bit got_done, got_abort, use_col;
        n        = int'(r) * int'(c);
        use_col  = cm && COLM_EN;
        n_exp    = (abort_at > 0) ? abort_at - 1 : n;
        exp_inck = use_col ? (int'(r) - 1) * int'(c) : 0;
        done_cyc = (n == 0) ? 1 : n + 2;
        push_exp(b, kk, r, c, use_col, n_exp);
        cmd_cnt  = 0;
        inck_cnt = 0;
        base_addr = b; k = kk; n_rows = r; n_cols = c; col_mode = cm; start = 1'b1;
        cyc = 0; got_done = 0; got_abort = 0;
        while (cyc < n + 12 && !got_done && !got_abort) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (spur_at > 0 && cyc == spur_at) start = 1'b1;
            if (spur_at > 0 && cyc == spur_at + 1) start = 1'b0;
            if (abort_at > 0 && cyc == abort_at) abort = 1'b1;
            if (abort_at > 0 && cyc == abort_at + 1) begin
                abort = 1'b0;
                got_abort = 1;
                chk("abort_ac_reset", ac_reset, 1);
                chk("abort_busy", busy, 0);
                chk("abort_elem_zero", {elem_valid, elem_row, elem_col, elem_addr, elem_last}, 0);
            end
            if (done) begin
                got_done = 1;
                chk("done_cycle", cyc, (abort_at > 0) ? 0 : done_cyc);
                chk("done_busy", busy, 0);
            end else if (!got_abort && n > 0 && cyc <= n + 1) begin
                chk("busy", busy, 1);
            end
        end
        start = 1'b0;
        abort = 1'b0;
        if (abort_at > 0) begin
            chk("abort_seen", got_abort, 1);
            @(negedge clk);
            chk("post_abort_ac_reset", ac_reset, 0);
            chk("post_abort_busy", busy, 0);
            chk("post_abort_done", done, 0);
        end else begin
            chk("done_seen", got_done, 1);
            chk("cmd_count", cmd_cnt, n);
            chk("inck_count", inck_cnt, exp_inck);
            @(negedge clk);
            chk("done_pulse_width", done, 0);
            chk("idle_busy", busy, 0);
        end
        chk("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic idle_start_abort();
        start = 1'b1;
        abort = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            chk("sa_busy", busy, 0);
            chk("sa_done", done, 0);
            chk("sa_ac_load", ac_load, 0);
        end
    endtask

    task automatic reset_mid();
        push_exp(16'h0040, 16'd10, 8'd3, 8'd3, 1'b0, 9);
        base_addr = 16'h0040; k = 16'd10; n_rows = 8'd3; n_cols = 8'd3; col_mode = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_mid_outputs", {ac_load, ac_data, ac_inc, ac_inck, ac_reset, elem_valid,
            elem_row, elem_col, elem_addr, elem_last, busy, done}, 0);
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r, c, ab, sp;
        reset = 1'b1; start = 1'b0; abort = 1'b0; col_mode = 1'b0;
        base_addr = '0; k = '0; n_rows = '0; n_cols = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {ac_load, ac_data, ac_inc, ac_inck, ac_reset, elem_valid,
            elem_row, elem_col, elem_addr, elem_last, busy, done}, 0);
        reset = 1'b0;
        @(negedge clk);

        run_walk(16'h0100, 16'd332, 8'd2, 8'd3, 1'b0, 0, 0);
        run_walk(16'h0100, 16'd332, 8'd2, 8'd3, 1'b1, 0, 0);
        run_walk(16'hFFFE, 16'd5,   8'd1, 8'd3, 1'b0, 0, 0);
        run_walk(16'h1234, 16'd7,   8'd0, 8'd4, 1'b0, 0, 0);
        run_walk(16'h1234, 16'd7,   8'd3, 8'd0, 1'b1, 0, 0);
        run_walk(16'h0100, 16'd332, 8'd2, 8'd3, 1'b0, 3, 0);
        run_walk(16'h0200, 16'd16,  8'd2, 8'd3, 1'b1, 0, 0);
        run_walk(16'h0400, 16'd3,   8'd2, 8'd2, 1'b0, 1, 0);
        run_walk(16'h0300, 16'd9,   8'd2, 8'd3, 1'b0, 0, 3);
        idle_start_abort();
        reset_mid();
        run_walk(16'hFFF0, 16'hFFF9, 8'd3, 8'd2, 1'b1, 0, 0);

        for (int i = 0; i < 24; i++) begin
            r  = $urandom_range(1, 4);
            c  = $urandom_range(1, 5);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, r * c + 1) : 0;
            sp = (ab == 0 && $urandom_range(0, 2) == 0) ? $urandom_range(2, r * c + 1) : 0;
            run_walk(16'($urandom), 16'($urandom), 8'(r), 8'(c), 1'($urandom_range(0, 1)), ab, sp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
